// File: rtl/inv_round_permutation_seq.sv
// inv_round_permutation_seq: serial per-word rotate-right that undoes the round permutation
module inv_round_permutation_seq #(
  parameter int unsigned DATA_LENGTH = 16,
  parameter int unsigned NUM_WORDS   = 4,
  parameter int unsigned SHIFT_W0    = 1,
  parameter int unsigned SHIFT_W1    = 4,
  parameter int unsigned SHIFT_W2    = 7,
  parameter int unsigned SHIFT_W3    = 9
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_LENGTH*NUM_WORDS-1:0] in_state,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_LENGTH*NUM_WORDS-1:0] out_state,
  output logic                             busy
);
  localparam int unsigned CW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;
  if (SHIFT_W0 >= DATA_LENGTH || SHIFT_W1 >= DATA_LENGTH ||
      SHIFT_W2 >= DATA_LENGTH || SHIFT_W3 >= DATA_LENGTH) begin : g_bad_shift
    $error("rotate amounts must be less than DATA_LENGTH");
  end
  fsm_t                             fsm, fsm_nxt;
  logic [CW-1:0]                    cnt, cnt_nxt;
  logic [DATA_LENGTH*NUM_WORDS-1:0] st, st_nxt;
  logic [DATA_LENGTH-1:0]           w, rot;
  int unsigned                      s;
  function automatic int unsigned shift_of(input logic [CW-1:0] i);
    return i == CW'(0) ? SHIFT_W0 : i == CW'(1) ? SHIFT_W1 : i == CW'(2) ? SHIFT_W2 : SHIFT_W3;
  endfunction
  // state register, word counter and working state; reset aborts any transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm <= IDLE;
      cnt <= '0;
      st  <= '0;
    end else begin
      fsm <= fsm_nxt;
      cnt <= cnt_nxt;
      st  <= st_nxt;
    end
  end
  // shared rotator on the current word plus next-state logic
  always_comb begin
    s       = shift_of(cnt);
    w       = st[cnt*DATA_LENGTH +: DATA_LENGTH];
    rot     = (w >> s) | (w << (DATA_LENGTH - s));
    fsm_nxt = fsm;
    cnt_nxt = cnt;
    st_nxt  = st;
    case (fsm)
      IDLE: if (in_valid) begin
        st_nxt  = in_state;
        cnt_nxt = '0;
        fsm_nxt = BUSY;
      end
      BUSY: begin
        st_nxt[cnt*DATA_LENGTH +: DATA_LENGTH] = rot;
        cnt_nxt = cnt + 1'b1;
        fsm_nxt = cnt == CW'(NUM_WORDS - 1) ? DONE : BUSY;
      end
      DONE: fsm_nxt = out_ready ? IDLE : DONE;
      default: fsm_nxt = IDLE;
    endcase
  end
  assign in_ready  = fsm == IDLE;
  assign out_valid = fsm == DONE;
  assign busy      = fsm != IDLE;
  assign out_state = st;
endmodule

// File: tb/tb_inv_round_permutation_seq.sv
// tb_inv_round_permutation_seq: scoreboard bench for the inverse round permutation
module tb_inv_round_permutation_seq;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [63:0] in_state = '0;
  logic        in_ready, out_valid, busy;
  logic [63:0] out_state;
  int          vectors = 0, miscompares = 0;
  logic [63:0] sb[$];

  inv_round_permutation_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rol_state(input logic [63:0] x);
    int unsigned sh[4] = '{1, 4, 7, 9};
    logic [15:0] w;
    logic [63:0] r;
    for (int i = 0; i < 4; i++) begin
      w = x[16*i +: 16];
      r[16*i +: 16] = (w << sh[i]) | (w >> (16 - sh[i]));
    end
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send(input logic [63:0] raw, input logic [63:0] exp);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    in_valid = 1;
    in_state = raw;
    sb.push_back(exp);
    @(negedge clk);
    in_valid = 0;
    in_state = rnd64();
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic receive(input int hold);
    int lat;
    logic [63:0] exp = '0;
    out_ready = hold == 0;
    wait_valid(lat);
    chk("latency", lat, 4);
    chk("sb_size", sb.size(), 1);
    if (sb.size() != 0) exp = sb.pop_front();
    chk("out_state", out_state, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_state", out_state, exp);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    out_ready = 0;
  endtask

  initial begin
    int lat;
    logic [63:0] a, b, c;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_state", out_state, 0);
    rst_n = 1;
    @(negedge clk);
    send(64'h0200_0080_1234_8001, 64'h0001_0001_4123_C000);
    receive(0);
    send(64'h0200_0080_1234_8001, 64'h0001_0001_4123_C000);
    receive(10);
    a = rnd64();
    b = rnd64();
    out_ready = 1;
    in_valid = 1;
    in_state = rol_state(a);
    sb.push_back(a);
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_state = rnd64();
      chk("busy_in_ready", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    chk("hv_latency", lat, 4);
    chk("hv_first", out_state, sb.pop_front());
    in_state = rol_state(b);
    sb.push_back(b);
    @(negedge clk);
    chk("no_accept_in_done", busy, 0);
    chk("idle_in_ready", in_ready, 1);
    @(negedge clk);
    chk("second_accepted", busy, 1);
    in_valid = 0;
    wait_valid(lat);
    chk("hv2_latency", lat, 4);
    chk("hv_second", out_state, sb.pop_front());
    @(negedge clk);
    out_ready = 0;
    c = rnd64();
    send(rol_state(c), c);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    void'(sb.pop_back());
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_state", out_state, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_output", out_valid, 0);
    end
    c = rnd64();
    send(rol_state(c), c);
    receive(0);
    for (int i = 0; i < 1000; i++) begin
      a = rnd64();
      send(rol_state(a), a);
      receive(int'($urandom_range(0, 2)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
